// File: rtl/ps2_key_event_fifo_if.sv
// Handshake bundle for the PS/2 key-event FIFO: scan-code input strobe,
// event output with valid/ready, occupancy and sticky overflow status.
interface ps2_key_event_fifo_if #(
  parameter int AW = 3
) ();
  logic          code_vld;
  logic [7:0]    code;
  logic          code_err;
  logic          ev_valid;
  logic          ev_ready;
  logic [9:0]    ev_data;
  logic [AW:0]   count;
  logic          overflow;
  logic          clr_ovf;

  modport slave (
    input  code_vld, code, code_err, ev_ready, clr_ovf,
    output ev_valid, ev_data, count, overflow
  );

  modport master (
    output code_vld, code, code_err, ev_ready, clr_ovf,
    input  ev_valid, ev_data, count, overflow
  );
endinterface

// File: rtl/ps2_key_event_fifo.sv
// Folds E0/F0-prefixed PS/2 scan-code sequences into {brk,ext,code} events and
// buffers them in a first-word-fall-through FIFO. Optional: PS2_TYPEMATIC_FILTER_EN.
module ps2_key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_key_event_fifo_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GOT_E0,
    S_GOT_F0,
    S_GOT_E0F0
  } state_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ev_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_e          state_q, state_d;
  logic            emit;
  ev_t             emit_ev;
  logic            push;
  logic            push_acc;
  logic            pop;
  logic            is_reply;

  ev_t             mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q;

  // Keyboard command replies that never represent a key in the idle state.
  always_comb begin
    unique case (bus.code)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_reply = 1'b1;
      default:                                   is_reply = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    emit_ev = '0;
    if (bus.code_vld) begin
      if (bus.code_err) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.code == 8'hE0)      state_d = S_GOT_E0;
            else if (bus.code == 8'hF0) state_d = S_GOT_F0;
            else if (!is_reply) begin
              emit    = 1'b1;
              emit_ev = '{brk: 1'b0, ext: 1'b0, code: bus.code};
            end
          end
          S_GOT_E0: begin
            if (bus.code == 8'hF0)      state_d = S_GOT_E0F0;
            else if (bus.code != 8'hE0) begin
              emit    = 1'b1;
              emit_ev = '{brk: 1'b0, ext: 1'b1, code: bus.code};
              state_d = S_IDLE;
            end
          end
          S_GOT_F0: begin
            if (bus.code == 8'hE0)      state_d = S_GOT_E0;
            else if (bus.code != 8'hF0) begin
              emit    = 1'b1;
              emit_ev = '{brk: 1'b1, ext: 1'b0, code: bus.code};
              state_d = S_IDLE;
            end
          end
          S_GOT_E0F0: begin
            if (bus.code == 8'hE0)      state_d = S_GOT_E0;
            else if (bus.code != 8'hF0) begin
              emit    = 1'b1;
              emit_ev = '{brk: 1'b1, ext: 1'b1, code: bus.code};
              state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] held_q, held_d;
  logic       held_vld_q, held_vld_d;

  // Repeated makes of the held key are auto-repeat; its break releases it.
  always_comb begin
    held_d     = held_q;
    held_vld_d = held_vld_q;
    push       = emit;
    if (emit) begin
      if (!emit_ev.brk) begin
        if (held_vld_q && held_q == {emit_ev.ext, emit_ev.code}) begin
          push = 1'b0;
        end else begin
          held_d     = {emit_ev.ext, emit_ev.code};
          held_vld_d = 1'b1;
        end
      end else if (held_vld_q && held_q == {emit_ev.ext, emit_ev.code}) begin
        held_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else begin
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
    end
  end
`else
  assign push = emit;
`endif

  // When full, a same-cycle pop frees the slot the push writes into.
  assign pop      = (count_q != '0) && bus.ev_ready;
  assign push_acc = push && ((count_q != FULL_CNT) || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (push && !push_acc) overflow_q <= 1'b1;
      else if (bus.clr_ovf)  overflow_q <= 1'b0;
    end
  end

  // NOTE: storage is left unreset; contents are only observed behind count/ev_valid.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= emit_ev;
  end

  assign bus.ev_valid = (count_q != '0);
  assign bus.ev_data  = mem[rd_ptr_q];
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed bench for ps2_key_event_fifo: scoreboard of expected events,
// checked by immediate assertions as the FIFO is drained.
module tb_ps2_key_event_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_key_event_fifo_if #(.AW(AW)) bus ();

  ps2_key_event_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [9:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    @(negedge clk);
    bus.code_vld = 1'b1;
    bus.code     = b;
    bus.code_err = err;
    @(negedge clk);
    bus.code_vld = 1'b0;
    bus.code_err = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget = 40;
    logic [9:0] e;
    bus.ev_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      if (bus.ev_valid) begin
        e = exp_q.pop_front();
        check({tag, " data"}, 32'(bus.ev_data), 32'(e));
      end
      @(negedge clk);
      budget--;
    end
    bus.ev_ready = 1'b0;
    check({tag, " leftover"}, 32'(exp_q.size()), 32'd0);
    check({tag, " empty"}, 32'(bus.ev_valid), 32'd0);
    check({tag, " count0"}, 32'(bus.count), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [9:0] e;
    bus.code_vld = 1'b0;
    bus.code     = '0;
    bus.code_err = 1'b0;
    bus.ev_ready = 1'b0;
    bus.clr_ovf  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset ev_valid", 32'(bus.ev_valid), 32'd0);
    check("reset count", 32'(bus.count), 32'd0);
    check("reset overflow", 32'(bus.overflow), 32'd0);

    // Single make, one-cycle latency
    send(8'h1C);
    check("1C ev_valid", 32'(bus.ev_valid), 32'd1);
    check("1C count", 32'(bus.count), 32'd1);
    exp_q.push_back(10'h01C);
    drain("make 1C");

    // Prefixed sequences
    send(8'hF0); send(8'h1C); exp_q.push_back(10'h21C);
    check("F0,1C count", 32'(bus.count), 32'd1);
    send(8'hE0); send(8'h75); exp_q.push_back(10'h175);
    send(8'hE0); send(8'hF0); send(8'h75); exp_q.push_back(10'h375);
    check("prefix count", 32'(bus.count), 32'd3);
    drain("prefix");

    // Errored byte resets the prefix state
    send(8'hF0); send(8'h1C, 1'b1);
    check("err count", 32'(bus.count), 32'd0);
    send(8'h1C); exp_q.push_back(10'h01C);
    drain("after err");

    // Keyboard replies only filtered in idle
    send(8'hAA); send(8'hFA);
    check("replies count", 32'(bus.count), 32'd0);
    send(8'hF0); send(8'hAA); exp_q.push_back(10'h2AA);
    drain("F0,AA");

    // Overflow: DEPTH+1 makes with no reader
    for (int i = 0; i <= DEPTH; i++) begin
      send(8'(8'h10 + i));
      if (i < DEPTH) exp_q.push_back(10'(8'h10 + i));
    end
    check("full count", 32'(bus.count), 32'(DEPTH));
    check("full overflow", 32'(bus.overflow), 32'd1);
    check("full head", 32'(bus.ev_data), 32'h010);

    // Set wins over clear in the same cycle
    @(negedge clk);
    bus.code_vld = 1'b1; bus.code = 8'h30; bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.code_vld = 1'b0; bus.clr_ovf = 1'b0;
    check("set-prio overflow", 32'(bus.overflow), 32'd1);
    check("set-prio count", 32'(bus.count), 32'(DEPTH));

    @(negedge clk); bus.clr_ovf = 1'b1;
    @(negedge clk); bus.clr_ovf = 1'b0;
    check("clr overflow", 32'(bus.overflow), 32'd0);

    // Push and pop together while full
    @(negedge clk);
    e = exp_q.pop_front();
    check("pp head", 32'(bus.ev_data), 32'(e));
    bus.code_vld = 1'b1; bus.code = 8'h20; bus.ev_ready = 1'b1;
    exp_q.push_back(10'h020);
    @(negedge clk);
    bus.code_vld = 1'b0; bus.ev_ready = 1'b0;
    check("pp count", 32'(bus.count), 32'(DEPTH));
    check("pp overflow", 32'(bus.overflow), 32'd0);
    drain("full drain");

    // Typematic repeat
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_q.push_back(10'h01C); exp_q.push_back(10'h21C); exp_q.push_back(10'h01C);
`else
    exp_q.push_back(10'h01C); exp_q.push_back(10'h01C); exp_q.push_back(10'h01C);
    exp_q.push_back(10'h21C); exp_q.push_back(10'h01C); exp_q.push_back(10'h01C);
`endif
    check("typematic count", 32'(bus.count), 32'(exp_q.size()));
    drain("typematic");

    // Reset in the middle of a prefix
    send(8'hE0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midreset count", 32'(bus.count), 32'd0);
    check("midreset ev_valid", 32'(bus.ev_valid), 32'd0);
    send(8'h75); exp_q.push_back(10'h075);
    drain("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
